// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access size encodings,
// controller states and the wait-counter width.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter for the data memory.
// Store side: byte-enable mask and lane-replicated write data.
// Load side: addressed byte/half selection with sign or zero extension.
// Also flags half/word accesses that are not naturally aligned.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store path: replicate the right-justified data into every lane it could land in
    always_comb begin
        be       = 4'b0000;
        wdata_al = 32'h0;
        case (size)
            SZ_BYTE: begin
                be       = 4'b0001 << lane;
                wdata_al = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                be       = 4'b1111;
                wdata_al = wdata;
            end
            default: begin
                be       = 4'b0000;
                wdata_al = 32'h0;
            end
        endcase
    end

    // Load path: pick the addressed lane(s) and extend to 32 bits
    always_comb begin
        byte_sel  = rword[{lane, 3'b000} +: 8];
        half_sel  = lane[1] ? rword[31:16] : rword[15:0];
        rdata_ext = 32'h0;
        case (size)
            SZ_BYTE: rdata_ext = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata_ext = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            SZ_WORD: rdata_ext = rword;
            default: rdata_ext = 32'h0;
        endcase
    end

    // Alignment check: halves need an even address, words a multiple of four
    always_comb begin
        misaligned = ((size == SZ_HALF) && lane[0]) ||
                     ((size == SZ_WORD) && (lane != 2'b00));
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Parametrised byte-addressed data memory with a valid/ready request port,
// configurable wait states and an error response for misaligned,
// illegal-size or out-of-range accesses.
// Optional feature: define DMEM_CLEAR_EN to zero the whole array after each
// reset (one word per cycle) before requests are accepted.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 32,
    parameter int WAIT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

`ifdef DMEM_CLEAR_EN
    localparam state_e RESET_ST = ST_CLEAR;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
`else
    localparam state_e RESET_ST = ST_IDLE;
`endif

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ready_q, ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [31:0]        mem [DEPTH];
    logic [IDX_W-1:0]   widx;
    logic [31:0]        raw_word;
    logic [3:0]         be;
    logic [31:0]        wdata_al;
    logic [31:0]        rdata_ext;
    logic               misaligned;
    logic               out_of_range;
    logic               acc_err;
    logic               access;
    logic               mem_we;

    dmem_lane_fmt u_fmt (
        .size        (size_q),
        .lane        (addr_q[1:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rword       (raw_word),
        .be          (be),
        .wdata_al    (wdata_al),
        .rdata_ext   (rdata_ext),
        .misaligned  (misaligned)
    );

    // Decode the latched request: word index, error conditions and the access strobe
    always_comb begin
        widx         = addr_q[IDX_W+1:2];
        raw_word     = mem[widx];
        out_of_range = (addr_q >> (IDX_W + 2)) != '0;
        acc_err      = (size_q == SZ_ILLEGAL) || misaligned || out_of_range;
        access       = (state_q == ST_BUSY) && (cnt_q == '0);
        mem_we       = access && we_q && !acc_err;
    end

    // Next-state logic for the controller and its registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef DMEM_CLEAR_EN
        clr_idx_d   = clr_idx_q;
`endif
        case (state_q)
            ST_CLEAR: begin
`ifdef DMEM_CLEAR_EN
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_W'(WAIT_CYC);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (acc_err || we_q) ? 32'h0 : rdata_ext;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = RESET_ST;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Controller state and response registers; reset discards any in-flight request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_ST;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
`ifdef DMEM_CLEAR_EN
            clr_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef DMEM_CLEAR_EN
            clr_idx_q   <= clr_idx_d;
`endif
        end
    end

    // Storage array: byte-masked writes on the access edge, no reset of contents
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata_al[8*i +: 8];
                end
            end
        end
`ifdef DMEM_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            mem[clr_idx_q] <= 32'h0;
        end
`endif
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
